// File: rtl/asip_pkg.sv
// Shared definitions for the interpolation ASIP front end.
package asip_pkg;

    localparam logic [4:0]  OP_HALT          = 5'b11111;
    localparam logic [4:0]  OP_NOP           = 5'b00000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_HALT
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding buffer for a fetched word (and its PC) that arrived while
// the IF/ID register was stalled.
module fetch_skid_buf #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               clear_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [ADDR_W-1:0]  pc_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  pc_o
);

    logic [INSTR_W-1:0] instr_q;
    logic [ADDR_W-1:0]  pc_q;

    // NOTE: a single entry is just flops, so it takes the async reset like any other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= '0;
            pc_q    <= '0;
        end else if (clear_i) begin
            instr_q <= '0;
            pc_q    <= '0;
        end else if (load_i) begin
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC, single-outstanding imem read FSM, IF/ID register,
// redirect flush with drop of an in-flight response, and halt detection.
module instr_fetch_unit
    import asip_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc,
    output logic [4:0]         OPcode,
    output logic               halted
);

    fetch_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
    logic               drop_q, drop_d;
    logic               id_valid_q, id_valid_d;
    logic [INSTR_W-1:0] id_instr_q, id_instr_d;
    logic [ADDR_W-1:0]  id_pc_q, id_pc_d;

    logic               skid_load, skid_clear;
    logic [INSTR_W-1:0] skid_instr;
    logic [ADDR_W-1:0]  skid_pc;
    logic               load_en;
    logic [INSTR_W-1:0] load_instr;
    logic [ADDR_W-1:0]  load_pc;

    fetch_skid_buf #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .instr_i (imem_rdata),
        .pc_i    (req_pc_q),
        .instr_o (skid_instr),
        .pc_o    (skid_pc)
    );

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        drop_d     = drop_q;
        id_valid_d = id_valid_q;
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        load_en    = 1'b0;
        load_instr = '0;
        load_pc    = '0;

        if (redirect && state_q != ST_HALT) begin
            // A response still owed by memory must be swallowed before refetching.
            pc_d       = redirect_pc;
            id_valid_d = 1'b0;
            skid_clear = 1'b1;
            drop_d     = (state_q == ST_WAIT && !imem_rvalid) ||
                         (state_q == ST_REQ  && imem_gnt);
            state_d    = drop_d ? ST_WAIT : ST_REQ;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_REQ;
                ST_REQ: begin
                    if (imem_gnt) begin
                        state_d  = ST_WAIT;
                        req_pc_d = pc_q;
                        pc_d     = pc_q + ADDR_W'(4);
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = ST_REQ;
                        end else if (stall) begin
                            skid_load = 1'b1;
                            state_d   = ST_HOLD;
                        end else begin
                            load_en    = 1'b1;
                            load_instr = imem_rdata;
                            load_pc    = req_pc_q;
                            state_d    = ST_REQ;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        load_en    = 1'b1;
                        load_instr = skid_instr;
                        load_pc    = skid_pc;
                        state_d    = ST_REQ;
                    end
                end
                ST_HALT: ;
                default: state_d = ST_IDLE;
            endcase

            if (load_en) begin
                id_valid_d = 1'b1;
                id_instr_d = load_instr;
                id_pc_d    = load_pc;
                if (load_instr[INSTR_W-1 -: 5] == OP_HALT) begin
                    state_d = ST_HALT;
                end
            end else if (!stall && state_q != ST_HALT) begin
                id_valid_d = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            drop_q     <= 1'b0;
            id_valid_q <= 1'b0;
            id_instr_q <= '0;
            id_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            drop_q     <= drop_d;
            id_valid_q <= id_valid_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
        end
    end

    assign imem_req  = (state_q == ST_REQ);
    assign imem_addr = pc_q;
    assign id_valid  = id_valid_q;
    assign id_instr  = id_instr_q;
    assign id_pc     = id_pc_q;
    assign OPcode    = id_valid_q ? id_instr_q[INSTR_W-1 -: 5] : OP_NOP;
    assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench: random memory timing, stalls and redirects compared against
// a transaction-level model of the fetch stream and the IF/ID register.
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC    = 32'h0000_0000;
    localparam logic [31:0] HALT_ADDR = 32'h0000_0010;

    logic        clk, rst_n;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        stall, redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_instr, id_pc;
    logic [4:0]  OPcode;
    logic        halted;

    instr_fetch_unit #(
        .ADDR_W   (32),
        .INSTR_W  (32),
        .RESET_PC (RST_PC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .OPcode      (OPcode),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Memory and reference model state
    int          gnt_pct, lat_min, lat_max;
    bit          halt_en;
    logic        fl_v, fl_killed;
    logic [31:0] fl_addr;
    int          fl_cnt;
    logic        m_valid, m_halted, pend_v;
    logic [31:0] m_instr, m_pc, pend_instr, pend_pc, exp_addr;
    int          n_loaded;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (halt_en && a == HALT_ADDR) return {5'b11111, 27'h0000123};
        return a >> 2;
    endfunction

    task automatic model_reset();
        fl_v = 1'b0; fl_killed = 1'b0; fl_addr = '0; fl_cnt = 0;
        m_valid = 1'b0; m_instr = '0; m_pc = '0; m_halted = 1'b0;
        pend_v = 1'b0; pend_instr = '0; pend_pc = '0;
        exp_addr = RST_PC; n_loaded = 0;
    endtask

    task automatic model_load(input logic [31:0] w, input logic [31:0] a);
        m_valid = 1'b1; m_instr = w; m_pc = a; n_loaded++;
        if (w[31:27] == 5'b11111) m_halted = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req"},    32'(imem_req), 32'd0);
        check({tag, "_addr"},   imem_addr,     RST_PC);
        check({tag, "_valid"},  32'(id_valid), 32'd0);
        check({tag, "_instr"},  id_instr,      32'd0);
        check({tag, "_pc"},     id_pc,         32'd0);
        check({tag, "_opcode"}, 32'(OPcode),   32'd0);
        check({tag, "_halted"}, 32'(halted),   32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
    endtask

    // One clock: called at a negedge, drives this cycle's inputs, then checks after the edge.
    task automatic tick(input logic st, input logic rd, input logic [31:0] rpc, input logic force_rv);
        logic        g, rv, live;
        logic [31:0] ga, ret_addr, ret_word;
        ga = imem_addr;
        g  = imem_req && !fl_v && !force_rv && (int'($urandom_range(99)) < gnt_pct);
        rv = 1'b0; live = 1'b0; ret_addr = fl_addr; ret_word = mem_word(fl_addr);
        if (fl_v) begin
            if (fl_cnt <= 1) begin
                rv   = 1'b1;
                live = !fl_killed && !rd;
            end else begin
                fl_cnt--;
            end
        end
        stall = st; redirect = rd; redirect_pc = rpc;
        imem_gnt = g; imem_rvalid = rv || force_rv;
        imem_rdata = rv ? ret_word : (force_rv ? 32'hDEAD_BEEF : $urandom());
        @(posedge clk);
        @(negedge clk);
        if (!m_halted) begin
            if (rv) fl_v = 1'b0;
            if (g) begin
                fl_v = 1'b1; fl_addr = ga; fl_killed = rd;
                fl_cnt = int'($urandom_range(lat_max, lat_min));
                exp_addr = ga + 32'd4;
            end
            if (rd) begin
                if (fl_v) fl_killed = 1'b1;
                exp_addr = rpc; m_valid = 1'b0; pend_v = 1'b0;
            end else if (st) begin
                if (live) begin pend_v = 1'b1; pend_instr = ret_word; pend_pc = ret_addr; end
            end else if (live) begin
                model_load(ret_word, ret_addr);
            end else if (pend_v) begin
                model_load(pend_instr, pend_pc);
                pend_v = 1'b0;
            end else begin
                m_valid = 1'b0;
            end
        end
        check("imem_req", 32'(imem_req), 32'(!m_halted && !fl_v && !pend_v));
        if (imem_req) check("imem_addr", imem_addr, exp_addr);
        check("id_valid", 32'(id_valid), 32'(m_valid));
        if (m_valid) begin
            check("id_instr", id_instr, m_instr);
            check("id_pc", id_pc, m_pc);
            check("OPcode", 32'(OPcode), 32'(m_instr[31:27]));
        end else begin
            check("OPcode_bubble", 32'(OPcode), 32'd0);
        end
        check("halted", 32'(halted), 32'(m_halted));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        halt_en = 0; gnt_pct = 100; lat_min = 1; lat_max = 1;
        do_reset();

        // Zero-wait stream: one word every two cycles after the IDLE cycle
        repeat (9) tick(1'b0, 1'b0, '0, 1'b0);
        check("stream_rate", 32'(n_loaded), 32'd4);
        check("stream_instr3", id_instr, 32'd3);
        check("stream_pc3", id_pc, 32'hC);
        repeat (8) tick(1'b0, 1'b0, '0, 1'b0);
        check("pre_stall_addr", imem_addr, 32'h20);

        // Stall for 3 cycles while word 8 returns
        repeat (3) tick(1'b1, 1'b0, '0, 1'b0);
        check("stall_hold_instr", id_instr, 32'd7);
        check("stall_no_req", 32'(imem_req), 32'd0);
        tick(1'b0, 1'b0, '0, 1'b0);
        check("stall_word", id_instr, 32'h8);

        // Redirect while the fetch of 0x20 is outstanding
        gnt_pct = 0;
        tick(1'b0, 1'b1, 32'h20, 1'b0);
        gnt_pct = 100; lat_min = 3; lat_max = 3;
        tick(1'b0, 1'b0, '0, 1'b0);
        tick(1'b0, 1'b1, 32'h100, 1'b0);
        check("redir_wait_flush", 32'(id_valid), 32'd0);
        budget = 10;
        while (!imem_req && budget > 0) begin
            tick(1'b0, 1'b0, '0, 1'b0);
            budget--;
        end
        check("redir_wait_addr", imem_addr, 32'h100);
        lat_min = 1; lat_max = 1;
        repeat (2) tick(1'b0, 1'b0, '0, 1'b0);
        check("redir_wait_pc", id_pc, 32'h100);

        // Redirect in the same cycle as rvalid
        tick(1'b0, 1'b0, '0, 1'b0);
        tick(1'b0, 1'b1, 32'h200, 1'b0);
        check("redir_rv_valid", 32'(id_valid), 32'd0);
        check("redir_rv_addr", imem_addr, 32'h200);
        repeat (2) tick(1'b0, 1'b0, '0, 1'b0);
        check("redir_rv_pc", id_pc, 32'h200);

        // PC wrap
        gnt_pct = 0;
        tick(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        gnt_pct = 100;
        repeat (2) tick(1'b0, 1'b0, '0, 1'b0);
        check("wrap_pc", id_pc, 32'hFFFF_FFFC);
        check("wrap_next_addr", imem_addr, 32'h0);

        // Random traffic
        gnt_pct = 60; lat_min = 1; lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(99) < 30), ($urandom_range(99) < 5),
                 $urandom() & 32'hFFFF_FFFC, 1'b0);
        end

        // Async reset mid-WAIT, then late rvalid during IDLE/REQ
        gnt_pct = 100; lat_min = 3; lat_max = 3;
        budget = 20;
        while (!fl_v && budget > 0) begin
            tick(1'b0, 1'b0, '0, 1'b0);
            budget--;
        end
        check("reach_wait", 32'(fl_v), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async");
        do_reset();
        tick(1'b0, 1'b0, '0, 1'b1);
        tick(1'b0, 1'b0, '0, 1'b1);
        check("late_rv_ignored", 32'(id_valid), 32'd0);
        lat_min = 1; lat_max = 1;
        repeat (2) tick(1'b0, 1'b0, '0, 1'b0);
        check("post_reset_valid", 32'(id_valid), 32'd1);
        check("post_reset_pc", id_pc, RST_PC);

        // Halt
        halt_en = 1;
        do_reset();
        budget = 40;
        while (!m_halted && budget > 0) begin
            tick(1'b0, 1'b0, '0, 1'b0);
            budget--;
        end
        check("halt_reached", 32'(halted), 32'd1);
        for (int i = 0; i < 20; i++) begin
            tick(($urandom_range(99) < 30), (i == 5), 32'h100, 1'b0);
        end
        check("halt_quiet_req", 32'(imem_req), 32'd0);
        check("halt_keep_pc", id_pc, HALT_ADDR);
        check("halt_opcode", 32'(OPcode), 32'h1F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
